// File: rtl/z80_reg_file.sv
// Z80 register file: twelve 16-bit GP pairs on the data-side bus, PC/IR on the
// address-side bus, and bus switch SW4 bridging the two sides.
module z80_reg_file (
   input  logic           clk,
   input  logic           reset,
   input  logic           ctl_sw_4,
   input  logic           reg_sel_af,
   input  logic           reg_sel_af2,
   input  logic           reg_sel_bc,
   input  logic           reg_sel_bc2,
   input  logic           reg_sel_de,
   input  logic           reg_sel_de2,
   input  logic           reg_sel_hl,
   input  logic           reg_sel_hl2,
   input  logic           reg_sel_ix,
   input  logic           reg_sel_iy,
   input  logic           reg_sel_wz,
   input  logic           reg_sel_sp,
   input  logic           reg_sel_gp_hi,
   input  logic           reg_sel_gp_lo,
   input  logic           reg_gp_oe,
   input  logic           reg_sel_pc,
   input  logic           reg_sel_ir,
   input  logic           reg_sel_sys_hi,
   input  logic           reg_sel_sys_lo,
   input  logic           reg_sys_oe,
   inout  tri logic [7:0] db_hi_ds,
   inout  tri logic [7:0] db_lo_ds,
   inout  tri logic [7:0] dbus_hi_as,
   inout  tri logic [7:0] dbus_lo_as
);

   localparam int unsigned NUM_GP = 12;
   localparam int unsigned REG_W  = 16;
   localparam int unsigned IDX_AF = 0;
   localparam int unsigned IDX_SP = 11;

   logic [NUM_GP-1:0] gp_sel_c;
   logic [REG_W-1:0]  gp_q [NUM_GP];
   logic [REG_W-1:0]  pc_q;
   logic [REG_W-1:0]  ir_q;
   logic [REG_W-1:0]  gp_rd_c;
   logic [REG_W-1:0]  sys_rd_c;
   logic [7:0]        sys_src_hi_c;
   logic [7:0]        sys_src_lo_c;
   logic              gp_drv_c;
   logic              sys_drv_c;
   logic              bridge_c;

   // Bit order doubles as read priority: lowest set bit wins.
   assign gp_sel_c = {reg_sel_sp, reg_sel_wz, reg_sel_iy, reg_sel_ix,
                      reg_sel_hl2, reg_sel_hl, reg_sel_de2, reg_sel_de,
                      reg_sel_bc2, reg_sel_bc, reg_sel_af2, reg_sel_af};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_GP; i++) begin
            gp_q[i] <= (i == IDX_AF || i == IDX_SP) ? 16'hFFFF : 16'h0000;
         end
      end else if (!reg_gp_oe) begin
         for (int unsigned i = 0; i < NUM_GP; i++) begin
            if (gp_sel_c[i]) begin
               if (reg_sel_gp_hi) gp_q[i][15:8] <= db_hi_ds;
               if (reg_sel_gp_lo) gp_q[i][7:0]  <= db_lo_ds;
            end
         end
      end
   end

   // With SW4 closed the system registers load from the data side.
   assign sys_src_hi_c = ctl_sw_4 ? db_hi_ds : dbus_hi_as;
   assign sys_src_lo_c = ctl_sw_4 ? db_lo_ds : dbus_lo_as;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= 16'h0000;
         ir_q <= 16'h0000;
      end else if (!reg_sys_oe) begin
         if (reg_sel_pc && reg_sel_sys_hi) pc_q[15:8] <= sys_src_hi_c;
         if (reg_sel_pc && reg_sel_sys_lo) pc_q[7:0]  <= sys_src_lo_c;
         if (reg_sel_ir && reg_sel_sys_hi) ir_q[15:8] <= sys_src_hi_c;
         if (reg_sel_ir && reg_sel_sys_lo) ir_q[7:0]  <= sys_src_lo_c;
      end
   end

   always_comb begin
      gp_rd_c = '0;
      for (int i = NUM_GP - 1; i >= 0; i--) begin
         if (gp_sel_c[i]) gp_rd_c = gp_q[i];
      end
   end

   assign sys_rd_c  = reg_sel_pc ? pc_q : ir_q;
   assign gp_drv_c  = reg_gp_oe & (|gp_sel_c);
   assign sys_drv_c = reg_sys_oe & (reg_sel_pc | reg_sel_ir);
   // Cross-driving is only allowed when exactly one side is reading.
   assign bridge_c  = ctl_sw_4 & ~(reg_gp_oe & reg_sys_oe);

   assign db_hi_ds   = (gp_drv_c & reg_sel_gp_hi) ? gp_rd_c[15:8] :
                       (bridge_c & sys_drv_c & reg_sel_sys_hi) ? sys_rd_c[15:8] : 8'hzz;
   assign db_lo_ds   = (gp_drv_c & reg_sel_gp_lo) ? gp_rd_c[7:0] :
                       (bridge_c & sys_drv_c & reg_sel_sys_lo) ? sys_rd_c[7:0] : 8'hzz;
   assign dbus_hi_as = (sys_drv_c & reg_sel_sys_hi) ? sys_rd_c[15:8] :
                       (bridge_c & gp_drv_c & reg_sel_gp_hi) ? gp_rd_c[15:8] : 8'hzz;
   assign dbus_lo_as = (sys_drv_c & reg_sel_sys_lo) ? sys_rd_c[7:0] :
                       (bridge_c & gp_drv_c & reg_sel_gp_lo) ? gp_rd_c[7:0] : 8'hzz;

endmodule

// File: tb/tb_z80_reg_file.sv
// Bench for z80_reg_file: directed vector table, reset/write-block sequence and
// random traffic against a register-array model. Buses are pulled up, so an
// undriven lane reads 8'hFF.
module tb_z80_reg_file;

   localparam logic [11:0] S_AF = 12'h001;
   localparam logic [11:0] S_BC = 12'h004;
   localparam logic [11:0] S_HL = 12'h040;
   localparam logic [11:0] S_IX = 12'h100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ctl_sw_4;
   logic reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2, reg_sel_de, reg_sel_de2;
   logic reg_sel_hl, reg_sel_hl2, reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp;
   logic reg_sel_gp_hi, reg_sel_gp_lo, reg_gp_oe;
   logic reg_sel_pc, reg_sel_ir, reg_sel_sys_hi, reg_sel_sys_lo, reg_sys_oe;

   logic [3:0]  ext_en;
   logic [31:0] ext_val;   // {db_hi, db_lo, as_hi, as_lo}

   tri1 [7:0] db_hi_ds;
   tri1 [7:0] db_lo_ds;
   tri1 [7:0] dbus_hi_as;
   tri1 [7:0] dbus_lo_as;

   assign db_hi_ds   = ext_en[3] ? ext_val[31:24] : 8'hzz;
   assign db_lo_ds   = ext_en[2] ? ext_val[23:16] : 8'hzz;
   assign dbus_hi_as = ext_en[1] ? ext_val[15:8]  : 8'hzz;
   assign dbus_lo_as = ext_en[0] ? ext_val[7:0]   : 8'hzz;

   always #5 clk = ~clk;

   z80_reg_file dut (
      .clk(clk), .reset(reset), .ctl_sw_4(ctl_sw_4),
      .reg_sel_af(reg_sel_af), .reg_sel_af2(reg_sel_af2),
      .reg_sel_bc(reg_sel_bc), .reg_sel_bc2(reg_sel_bc2),
      .reg_sel_de(reg_sel_de), .reg_sel_de2(reg_sel_de2),
      .reg_sel_hl(reg_sel_hl), .reg_sel_hl2(reg_sel_hl2),
      .reg_sel_ix(reg_sel_ix), .reg_sel_iy(reg_sel_iy),
      .reg_sel_wz(reg_sel_wz), .reg_sel_sp(reg_sel_sp),
      .reg_sel_gp_hi(reg_sel_gp_hi), .reg_sel_gp_lo(reg_sel_gp_lo), .reg_gp_oe(reg_gp_oe),
      .reg_sel_pc(reg_sel_pc), .reg_sel_ir(reg_sel_ir),
      .reg_sel_sys_hi(reg_sel_sys_hi), .reg_sel_sys_lo(reg_sel_sys_lo), .reg_sys_oe(reg_sys_oe),
      .db_hi_ds(db_hi_ds), .db_lo_ds(db_lo_ds),
      .dbus_hi_as(dbus_hi_as), .dbus_lo_as(dbus_lo_as)
   );

   typedef struct {
      string       name;
      logic [11:0] sel;   // bit 0 = af ... bit 11 = sp
      logic [2:0]  g;     // {oe, hi, lo}
      logic [1:0]  pi;    // {pc, ir}
      logic [2:0]  s;     // {oe, hi, lo}
      logic        sw;
      logic [3:0]  en;
      logic [31:0] ext;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] m_gp[12];
   logic [15:0] m_pc;
   logic [15:0] m_ir;

   function automatic vec_t mk(string nm, logic [11:0] sel, logic [2:0] g, logic [1:0] pi,
                               logic [2:0] s, logic sw, logic [3:0] en,
                               logic [31:0] ext, logic [31:0] exp);
      vec_t v;
      v.name = nm; v.sel = sel; v.g = g; v.pi = pi; v.s = s; v.sw = sw;
      v.en = en; v.ext = ext; v.exp = exp;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 12; i++) m_gp[i] = 16'h0000;
      m_gp[0]  = 16'hFFFF;
      m_gp[11] = 16'hFFFF;
      m_pc = 16'h0000;
      m_ir = 16'h0000;
   endtask

   // Bus contents the model expects; lanes nobody drives read as the pull-up.
   function automatic logic [31:0] predict(vec_t v);
      logic [7:0] b[4];
      logic       d[4];
      logic       gd[4];
      logic       sd[4];
      logic [15:0] gw, sw;
      int pick;
      pick = -1;
      for (int i = 0; i < 12; i++) if (v.sel[i] && pick < 0) pick = i;
      gw = (pick >= 0) ? m_gp[pick] : 16'h0;
      sw = v.pi[1] ? m_pc : m_ir;
      for (int k = 0; k < 4; k++) begin b[k] = 8'hFF; d[k] = 1'b0; end
      gd[0] = v.g[2] && pick >= 0 && v.g[1];
      gd[1] = v.g[2] && pick >= 0 && v.g[0];
      sd[0] = v.s[2] && (v.pi != 2'b00) && v.s[1];
      sd[1] = v.s[2] && (v.pi != 2'b00) && v.s[0];
      // lanes: 0 db_hi, 1 db_lo, 2 as_hi, 3 as_lo
      if (gd[0]) begin b[0] = gw[15:8]; d[0] = 1'b1; end
      if (gd[1]) begin b[1] = gw[7:0];  d[1] = 1'b1; end
      if (sd[0]) begin b[2] = sw[15:8]; d[2] = 1'b1; end
      if (sd[1]) begin b[3] = sw[7:0];  d[3] = 1'b1; end
      if (v.sw && !(v.g[2] && v.s[2])) begin
         if (gd[0]) b[2] = gw[15:8];
         if (gd[1]) b[3] = gw[7:0];
         if (sd[0]) b[0] = sw[15:8];
         if (sd[1]) b[1] = sw[7:0];
      end
      for (int k = 0; k < 4; k++) if (v.en[3-k]) b[k] = v.ext[31-8*k -: 8];
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic model_write(input vec_t v, input logic [31:0] bus);
      logic [7:0] sh, sl;
      if (!v.g[2]) begin
         for (int i = 0; i < 12; i++) begin
            if (v.sel[i] && v.g[1]) m_gp[i][15:8] = bus[31:24];
            if (v.sel[i] && v.g[0]) m_gp[i][7:0]  = bus[23:16];
         end
      end
      sh = v.sw ? bus[31:24] : bus[15:8];
      sl = v.sw ? bus[23:16] : bus[7:0];
      if (!v.s[2]) begin
         if (v.pi[1] && v.s[1]) m_pc[15:8] = sh;
         if (v.pi[1] && v.s[0]) m_pc[7:0]  = sl;
         if (v.pi[0] && v.s[1]) m_ir[15:8] = sh;
         if (v.pi[0] && v.s[0]) m_ir[7:0]  = sl;
      end
   endtask

   task automatic apply(input vec_t v);
      {reg_sel_sp, reg_sel_wz, reg_sel_iy, reg_sel_ix, reg_sel_hl2, reg_sel_hl,
       reg_sel_de2, reg_sel_de, reg_sel_bc2, reg_sel_bc, reg_sel_af2, reg_sel_af} = v.sel;
      {reg_gp_oe, reg_sel_gp_hi, reg_sel_gp_lo} = v.g;
      {reg_sel_pc, reg_sel_ir} = v.pi;
      {reg_sys_oe, reg_sel_sys_hi, reg_sel_sys_lo} = v.s;
      ctl_sw_4 = v.sw;
      ext_en   = v.en;
      ext_val  = v.ext;
   endtask

   task automatic check(input string name, input logic [31:0] exp);
      logic [31:0] got;
      got = {db_hi_ds, db_lo_ds, dbus_hi_as, dbus_lo_as};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: buses {db_hi,db_lo,as_hi,as_lo} got=%h want=%h", name, got, exp);
      end
   endtask

   // Apply, check mid-cycle, then clock and keep the model in step.
   task automatic run_vec(input vec_t v, input logic [31:0] exp);
      apply(v);
      #1;
      check(v.name, exp);
      model_write(v, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   mode;

      tbl.push_back(mk("idle_drv",   12'h0, 3'b000, 2'b00, 3'b000, 1'b0, 4'hF, 32'hFECA55AA, 32'hFECA55AA));
      tbl.push_back(mk("idle_rel",   12'h0, 3'b000, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'hFFFFFFFF));
      tbl.push_back(mk("rst_bc",     S_BC,  3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'h0000FFFF));
      tbl.push_back(mk("rst_pc",     12'h0, 3'b000, 2'b10, 3'b111, 1'b0, 4'h0, 32'h0,        32'hFFFF0000));
      tbl.push_back(mk("rst_ir",     12'h0, 3'b000, 2'b01, 3'b111, 1'b0, 4'h0, 32'h0,        32'hFFFF0000));
      tbl.push_back(mk("wr_af",      S_AF,  3'b011, 2'b00, 3'b000, 1'b0, 4'hC, 32'h34120000, 32'h3412FFFF));
      tbl.push_back(mk("rd_af",      S_AF,  3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'h3412FFFF));
      tbl.push_back(mk("wr_hl",      S_HL,  3'b011, 2'b00, 3'b000, 1'b0, 4'hC, 32'hBEEF0000, 32'hBEEFFFFF));
      tbl.push_back(mk("wr_hl_hi",   S_HL,  3'b010, 2'b00, 3'b000, 1'b0, 4'h8, 32'h5A000000, 32'h5AFFFFFF));
      tbl.push_back(mk("rd_hl",      S_HL,  3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'h5AEFFFFF));
      tbl.push_back(mk("rd_hl_lo",   S_HL,  3'b101, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'hFFEFFFFF));
      tbl.push_back(mk("wr_pc",      12'h0, 3'b000, 2'b10, 3'b011, 1'b0, 4'h3, 32'h00008000, 32'hFFFF8000));
      tbl.push_back(mk("rd_pc_sw",   12'h0, 3'b000, 2'b10, 3'b111, 1'b1, 4'h0, 32'h0,        32'h80008000));
      tbl.push_back(mk("rd_pc_nosw", 12'h0, 3'b000, 2'b10, 3'b111, 1'b0, 4'h0, 32'h0,        32'hFFFF8000));
      tbl.push_back(mk("rd_prio",    S_AF|S_BC, 3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,    32'h3412FFFF));
      tbl.push_back(mk("wr_af_bc",   S_AF|S_BC, 3'b011, 2'b00, 3'b000, 1'b0, 4'hC, 32'h77660000, 32'h7766FFFF));
      tbl.push_back(mk("rd_bc",      S_BC,  3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'h7766FFFF));
      tbl.push_back(mk("rd_af_new",  S_AF,  3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0,        32'h7766FFFF));
      tbl.push_back(mk("rd_ix_sw",   S_IX,  3'b111, 2'b00, 3'b000, 1'b1, 4'h0, 32'h0,        32'h00000000));
      tbl.push_back(mk("rd_both_oe", S_HL,  3'b111, 2'b10, 3'b111, 1'b1, 4'h0, 32'h0,        32'h5AEF8000));
      tbl.push_back(mk("wr_ir_sw",   12'h0, 3'b000, 2'b01, 3'b011, 1'b1, 4'hC, 32'hC33C0000, 32'hC33CFFFF));
      tbl.push_back(mk("rd_ir",      12'h0, 3'b000, 2'b01, 3'b111, 1'b0, 4'h0, 32'h0,        32'hFFFFC33C));
      tbl.push_back(mk("rd_pc_ir",   12'h0, 3'b000, 2'b11, 3'b111, 1'b0, 4'h0, 32'h0,        32'hFFFF8000));
      tbl.push_back(mk("rd_sys_lo",  12'h0, 3'b000, 2'b10, 3'b101, 1'b1, 4'h0, 32'h0,        32'hFF00FF00));

      apply(mk("zero", 12'h0, 3'b000, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0, 32'h0));
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], tbl[i].exp);

      // Asynchronous reset in the middle of a read, then a write held off by reset.
      run_vec(mk("wr_bc", S_BC, 3'b011, 2'b00, 3'b000, 1'b0, 4'hC, 32'h12340000, 32'h1234FFFF), 32'h1234FFFF);
      apply(mk("rd_bc_pc", S_BC, 3'b111, 2'b10, 3'b111, 1'b0, 4'h0, 32'h0, 32'h0));
      #1 check("rd_bc_pc", 32'h12348000);
      #1 reset = 1'b1;
      #1 check("rst_mid_read", 32'h00000000);
      apply(mk("wr_hl_rst", S_HL, 3'b011, 2'b00, 3'b000, 1'b0, 4'hC, 32'h99990000, 32'h0));
      @(posedge clk);
      #1 reset = 1'b0;
      apply(mk("rd_hl_rst", S_HL, 3'b111, 2'b00, 3'b000, 1'b0, 4'h0, 32'h0, 32'h0));
      #1 check("wr_blocked_rst", 32'h0000FFFF);
      @(posedge clk);
      #1;
      model_reset();

      for (int n = 0; n < 400; n++) begin
         v.name = "random";
         v.sel  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : (12'(1) << $urandom_range(0, 11));
         v.pi   = 2'($urandom);
         v.sw   = 1'($urandom);
         v.g[1:0] = 2'($urandom);
         v.s[1:0] = 2'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 0) begin
            v.g[2] = 1'b0; v.s[2] = 1'b0;
            v.en  = 4'hF;
            v.ext = $urandom;
         end else begin
            v.g[2] = (mode != 2);
            v.s[2] = (mode != 1);
            v.en  = 4'h0;
            v.ext = 32'h0;
            if (!v.g[2]) v.sel = 12'h0;
            if (!v.s[2]) v.pi  = 2'b00;
         end
         v.exp = predict(v);
         run_vec(v, v.exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/z80_reg_file.md
# z80_reg_file

Z80 CPU register file: twelve 16-bit general-purpose (GP) register pairs and two 16-bit system registers (PC, IR). GP pairs connect to the data-side 8-bit bus pair. System registers connect to the address-side 8-bit bus pair. A bus switch (SW4) bridges the two sides. It sits between the ALU/data path and the address latch, and is controlled by decoded select/enable strobes from the sequencer.

## Interface
- No parameters.
- clk  input  1  single clock; all register writes on rising edge.
- reset  input  1  asynchronous, active-high.
- ctl_sw_4  input  1  bus switch #4; 1 = bridge data side and address side.
- reg_sel_af, reg_sel_af2, reg_sel_bc, reg_sel_bc2, reg_sel_de, reg_sel_de2, reg_sel_hl, reg_sel_hl2, reg_sel_ix, reg_sel_iy, reg_sel_wz, reg_sel_sp  input  1 each  GP pair selects.
- reg_sel_gp_hi / reg_sel_gp_lo  input  1 each  select high / low byte of the selected GP pair.
- reg_gp_oe  input  1  1 = read selected GP bytes onto the bus; 0 = write.
- reg_sel_pc, reg_sel_ir  input  1 each  system register selects.
- reg_sel_sys_hi / reg_sel_sys_lo  input  1 each  byte selects for the system register.
- reg_sys_oe  input  1  1 = read system register onto the bus; 0 = write.
- db_hi_ds, db_lo_ds  inout  8 each  data-side bus, tri-state.
- dbus_hi_as, dbus_lo_as  inout  8 each  address-side bus, tri-state.

## Operation
- GP write: on the clk rising edge, when reg_gp_oe=0, each asserted GP pair select with reg_sel_gp_hi=1 loads db_hi_ds into the high byte. With reg_sel_gp_lo=1 it loads db_lo_ds into the low byte. Unselected bytes and pairs hold.
- GP read: when reg_gp_oe=1, the selected pair's high byte drives db_hi_ds if reg_sel_gp_hi=1, and its low byte drives db_lo_ds if reg_sel_gp_lo=1. Undriven byte lanes are Z.
- If several GP pairs are selected, all of them are written. For reads, one pair is driven by priority: af, af2, bc, bc2, de, de2, hl, hl2, ix, iy, wz, sp.
- System write: on the clk edge, when reg_sys_oe=0, the selected PC/IR bytes (per reg_sel_sys_hi/lo) load from the address-side bus. When ctl_sw_4=1 they load from the data-side bus instead.
- System read: when reg_sys_oe=1, the selected bytes of PC drive dbus_*_as. IR drives instead if only reg_sel_ir is selected; PC wins if both are selected.
- Bus switch, ctl_sw_4=1:
  - a GP read also drives the same bytes onto dbus_*_as;
  - a system read also drives the same bytes onto db_*_ds.
  - If both reg_gp_oe and reg_sys_oe are 1, cross-driving is suppressed: each side drives only its own bus.
- With no output enable active, all four buses are Z and external drivers own them.
- Reset values: AF, SP = 16'hFFFF. PC, IR, and all other pairs = 16'h0000.
- Reset does not affect tri-state drive. Drive is combinational from the select/oe inputs.

## Timing
- Writes take effect at the clk rising edge. Read-after-write data is visible combinationally in the following cycle.
- Reads are combinational: bus drive follows the select/oe inputs with no latency.
- Reset is asynchronous: registers take their reset values immediately on assertion, and writes are blocked while reset=1.
- A reset during a read updates the driven values immediately. Drive enables are unchanged.
- A simultaneous write and read of the same register is impossible: oe=1 blocks the write.

## Test plan
- Buses idle: all selects and oe are 0; external drivers put AA/55/CA/FE on dbus_lo_as/dbus_hi_as/db_lo_ds/db_hi_ds, then release to Z -> each bus reads exactly the external value, then Z. The DUT never drives.
- GP write/readback: with db_lo_ds=12, db_hi_ds=34, assert reg_sel_af + gp_hi + gp_lo, oe=0, then clock. Next cycle, with buses released and oe=1 -> db_lo_ds=12, db_hi_ds=34.
- Byte select: write HL=BEEF, then write only the high byte with 5A -> HL reads 5AEF. A read with only gp_lo asserted drives EF while db_hi_ds stays Z.
- Reset: after writing BC=1234, assert reset mid-cycle -> BC=0000, AF=FFFF, SP=FFFF, PC=0000 immediately, before the next clk edge.
- Bus switch: load PC=8000 via dbus_*_as, then set reg_sys_oe=1 and ctl_sw_4=1 -> dbus=80/00 and db_*_ds=80/00. With ctl_sw_4=0 -> db_*_ds is Z.
- Priority: select af and bc together with oe=1 -> AF is driven. A write with both selected loads the same value into both pairs.
